result_readback_controller: RTL and testbench

Read-side sequencer for the processed image. Once the write-side controller signals `imageProcessed`, this block walks the output buffer memory segment by segment and bank by bank. It fetches every processed pixel through a one-cycle-latency RAM port and streams the pixels out over a valid/ready handshake with backpressure. It sits between the processed-image RAM banks and the downstream display/UART sink, and raises `frameDone` after the last pixel is accepted.

---
 rtl/result_readback_controller.sv | 185 ++++++++++++++++++
 tb/tb_result_readback_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_readback_controller.sv
// Read-side sequencer: walks the processed-image RAM segment by segment and streams
// every pixel out through a two-entry skid buffer with valid/ready backpressure.
module result_readback_controller #(
   parameter int SEG_LEN  = 2048,
   parameter int NUM_SEG  = 32,
   parameter int BANK_LEN = 256,
   parameter int PIX_W    = 8
) (
   input  logic                       readClk,
   input  logic                       resetRd,
   input  logic                       imageProcessed,
   output logic                       rdEn,
   output logic [$clog2(SEG_LEN)-1:0] rdAddr,
   output logic [2:0]                 bankSel,
   output logic [$clog2(NUM_SEG)-1:0] segSel,
   input  logic [PIX_W-1:0]           rdData,
   output logic [PIX_W-1:0]           pixOut,
   output logic                       pixValid,
   input  logic                       pixReady,
   output logic                       segDone,
   output logic                       frameDone,
   output logic                       busy
);
   localparam int AW = $clog2(SEG_LEN);
   localparam int GW = $clog2(NUM_SEG);
   localparam int CW = $clog2(SEG_LEN * NUM_SEG);
   localparam int BW = $clog2(BANK_LEN);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             ip_q;
   logic [AW-1:0]    addr_q, addr_d;
   logic [GW-1:0]    seg_q, seg_d;
   logic             inflight_q, inflight_d;
   logic [PIX_W-1:0] mem_q [2];
   logic [PIX_W-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       occ_q, occ_d;
   logic [CW-1:0]    acc_q, acc_d;
   logic             seg_done_q, seg_done_d;
   logic             frame_done_q, frame_done_d;

   logic             rise_s, pop_s, rd_en_s, last_rd_s;
   logic [1:0]       occ_next_s;

   // Next-state, read issue and skid-buffer bookkeeping.
   always_comb begin
      rise_s     = imageProcessed && !ip_q;
      pop_s      = (occ_q != 2'd0) && pixReady;
      // Credit counts the slot freed by this cycle's pop so full rate needs only two entries.
      occ_next_s = occ_q - {1'b0, pop_s} + {1'b0, inflight_q};
      last_rd_s  = (addr_q == AW'(SEG_LEN - 1)) && (seg_q == GW'(NUM_SEG - 1));
      rd_en_s    = (state_q == STREAM) && !resetRd && (occ_next_s < 2'd2);

      state_d      = state_q;
      addr_d       = addr_q;
      seg_d        = seg_q;
      inflight_d   = rd_en_s;
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q ^ inflight_q;
      rd_ptr_d     = rd_ptr_q ^ pop_s;
      occ_d        = occ_next_s;
      acc_d        = acc_q + CW'(pop_s);
      seg_done_d   = pop_s && (acc_q[AW-1:0] == {AW{1'b1}});
      frame_done_d = frame_done_q;

      if (inflight_q) begin
         mem_d[wr_ptr_q] = rdData;
      end else begin
         mem_d = mem_q;
      end

      if (pop_s && (acc_q == {CW{1'b1}})) begin
         frame_done_d = 1'b1;
      end else begin
         frame_done_d = frame_done_q;
      end

      case (state_q)
         IDLE: begin
            addr_d   = '0;
            seg_d    = '0;
            occ_d    = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            mem_d[0] = '0;
            mem_d[1] = '0;
            acc_d    = '0;
            if (rise_s) begin
               state_d = STREAM;
            end else begin
               state_d = IDLE;
            end
         end
         STREAM: begin
            if (rd_en_s) begin
               addr_d = addr_q + AW'(1);
               if (addr_q == AW'(SEG_LEN - 1)) begin
                  seg_d = seg_q + GW'(1);
               end else begin
                  seg_d = seg_q;
               end
               if (last_rd_s) begin
                  state_d = DRAIN;
               end else begin
                  state_d = STREAM;
               end
            end else begin
               state_d = STREAM;
            end
         end
         DRAIN: begin
            if (occ_next_s == 2'd0) begin
               state_d = DONE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            if (rise_s) begin
               state_d      = STREAM;
               addr_d       = '0;
               seg_d        = '0;
               acc_d        = '0;
               frame_done_d = 1'b0;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge readClk) begin
      if (resetRd) begin
         state_q      <= IDLE;
         ip_q         <= 1'b0;
         addr_q       <= '0;
         seg_q        <= '0;
         inflight_q   <= 1'b0;
         mem_q[0]     <= '0;
         mem_q[1]     <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         occ_q        <= 2'd0;
         acc_q        <= '0;
         seg_done_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ip_q         <= imageProcessed;
         addr_q       <= addr_d;
         seg_q        <= seg_d;
         inflight_q   <= inflight_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         acc_q        <= acc_d;
         seg_done_q   <= seg_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign rdEn      = rd_en_s;
   assign rdAddr    = addr_q;
   assign segSel    = seg_q;
   assign bankSel   = 3'(addr_q >> BW);
   assign pixValid  = (occ_q != 2'd0);
   assign pixOut    = mem_q[rd_ptr_q];
   assign segDone   = seg_done_q;
   assign frameDone = frame_done_q;
   assign busy      = (state_q == STREAM) || (state_q == DRAIN);

endmodule

// File: tb/tb_result_readback_controller.sv
// Bench for result_readback_controller: frame-level reference model (pixel index ->
// address/segment/value) checked every cycle, plus directed scenarios with literal pins.
module tb_result_readback_controller;
   localparam int SEG_LEN  = 256;
   localparam int NUM_SEG  = 8;
   localparam int BANK_LEN = 32;
   localparam int PIX_W    = 8;
   localparam int N        = SEG_LEN * NUM_SEG;

   logic       readClk = 1'b0;
   logic       resetRd;
   logic       imageProcessed;
   logic       pixReady;
   logic [7:0] rdData;
   logic       rdEn;
   logic [7:0] rdAddr;
   logic [2:0] bankSel;
   logic [2:0] segSel;
   logic [7:0] pixOut;
   logic       pixValid;
   logic       segDone;
   logic       frameDone;
   logic       busy;

   result_readback_controller #(
      .SEG_LEN(SEG_LEN), .NUM_SEG(NUM_SEG), .BANK_LEN(BANK_LEN), .PIX_W(PIX_W)
   ) dut (
      .readClk(readClk), .resetRd(resetRd), .imageProcessed(imageProcessed),
      .rdEn(rdEn), .rdAddr(rdAddr), .bankSel(bankSel), .segSel(segSel),
      .rdData(rdData), .pixOut(pixOut), .pixValid(pixValid), .pixReady(pixReady),
      .segDone(segDone), .frameDone(frameDone), .busy(busy)
   );

   always #5 readClk = ~readClk;

   // RAM model: one-cycle latency, data = address ^ segment
   always @(posedge readClk) begin
      if (resetRd) rdData <= 8'h00;
      else if (rdEn) rdData <= rdAddr ^ {5'd0, segSel};
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_pix(input int k);
      return 8'(k % SEG_LEN) ^ 8'(k / SEG_LEN);
   endfunction

   bit         model_on = 1'b0;
   int         mstate = 0;        // 0 idle, 1 frame in progress, 2 frame complete
   int         rd_idx = 0, acc_idx = 0, cyc = 0, fd_cyc = 0, sd_count = 0, frames_done = 0;
   bit         exp_fd = 1'b0, exp_sd = 1'b0, ip_prev = 1'b0, prev_stall = 1'b0, full_rate = 1'b0;
   bit         hs, was_active;
   logic [7:0] prev_pix;
   logic [7:0] pin255 = 8'hxx, pin300 = 8'hxx, pin1000 = 8'hxx;

   always @(negedge readClk) begin
      if (model_on) begin
         if (mstate == 1) cyc++;
         chk("busy", busy, mstate == 1);
         chk("frameDone", frameDone, exp_fd);
         chk("segDone", segDone, exp_sd);
         chk("rdAddr", rdAddr, rd_idx % SEG_LEN);
         chk("segSel", segSel, (rd_idx / SEG_LEN) % NUM_SEG);
         chk("bankSel", bankSel, ((rd_idx % SEG_LEN) / BANK_LEN) % 8);
         chk("outstanding_le2", (rd_idx - acc_idx) <= 2, 1);
         if (rdEn) chk("rdEn_legal", (mstate == 1) && (rd_idx < N), 1);
         if (mstate != 1) chk("pixValid_idle", pixValid, 0);
         if (prev_stall) begin
            chk("stall_valid_held", pixValid, 1);
            chk("stall_pix_held", pixOut, prev_pix);
         end
         if (full_rate && mstate == 1) begin
            chk("fullrate_rdEn", rdEn, rd_idx < N);
            chk("fullrate_pixValid", pixValid, cyc >= 3);
         end
         hs = pixValid && pixReady;
         if (hs) begin
            chk("pix_in_frame", acc_idx < N, 1);
            chk("pixOut", pixOut, exp_pix(acc_idx));
         end
         if (segDone) sd_count++;

         if (resetRd) begin
            mstate = 0; rd_idx = 0; acc_idx = 0; exp_fd = 1'b0; exp_sd = 1'b0;
            ip_prev = 1'b0; prev_stall = 1'b0;
         end else begin
            was_active = (mstate == 1);
            exp_sd = hs && ((acc_idx % SEG_LEN) == SEG_LEN - 1);
            if (rdEn) rd_idx++;
            if (hs) begin
               if (frames_done == 0 && acc_idx == 255)  pin255  = pixOut;
               if (frames_done == 0 && acc_idx == 300)  pin300  = pixOut;
               if (frames_done == 0 && acc_idx == 1000) pin1000 = pixOut;
               acc_idx++;
               if (acc_idx == N) begin
                  mstate = 2; exp_fd = 1'b1; fd_cyc = cyc + 1; frames_done++;
               end
            end
            if (imageProcessed && !ip_prev && !was_active) begin
               mstate = 1; rd_idx = 0; acc_idx = 0; exp_fd = 1'b0; cyc = 0; sd_count = 0;
            end
            ip_prev    = imageProcessed;
            prev_stall = pixValid && !pixReady;
            prev_pix   = pixOut;
         end
      end
   end

   task automatic tick();
      @(posedge readClk);
      #1;
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_rdEn"}, rdEn, 0);
      chk({tag, "_rdAddr"}, rdAddr, 0);
      chk({tag, "_bankSel"}, bankSel, 0);
      chk({tag, "_segSel"}, segSel, 0);
      chk({tag, "_pixValid"}, pixValid, 0);
      chk({tag, "_pixOut"}, pixOut, 0);
      chk({tag, "_segDone"}, segDone, 0);
      chk({tag, "_frameDone"}, frameDone, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // mode 0: ready=1, 1: random ready, 2: stall at segment boundary, 3: toggle imageProcessed
   task automatic run_frame(input int mode);
      int n, stall_left, f0;
      bit stalled;
      n = 0; stall_left = 0; stalled = 1'b0; f0 = frames_done;
      imageProcessed = 1'b0; pixReady = 1'b1;
      tick(); tick();
      full_rate = (mode == 0 || mode == 3);
      imageProcessed = 1'b1;
      if (mode == 1) pixReady = 1'($urandom_range(0, 1));
      tick();
      while (!frameDone && n < 8 * N) begin
         case (mode)
            1: pixReady = 1'($urandom_range(0, 1));
            2: begin
               if (stall_left > 0) begin
                  stall_left--;
                  if (stall_left == 50) begin
                     chk("stall_rdEn", rdEn, 0);
                     chk("stall_segSel", segSel, 1);
                     chk("stall_rdAddr", rdAddr, 0);
                     chk("stall_head", pixOut, 254);
                  end
                  pixReady = 1'b0;
               end else if (!stalled && acc_idx == SEG_LEN - 2) begin
                  stalled = 1'b1; stall_left = 99; pixReady = 1'b0;
               end else begin
                  pixReady = 1'b1;
               end
            end
            3: begin
               if (n >= 100 && n < 120) imageProcessed = ~imageProcessed;
               else if (n == 500) imageProcessed = 1'b0;
               else if (n == 510) imageProcessed = 1'b1;
            end
            default: pixReady = 1'b1;
         endcase
         tick();
         n++;
      end
      chk("frame_done_reached", frameDone, 1);
      pixReady = 1'b1;
      repeat (20) tick();
      chk("accepted_count", acc_idx, N);
      chk("segDone_pulses", sd_count, NUM_SEG);
      chk("frames_completed", frames_done, f0 + 1);
      if (full_rate) chk("frameDone_latency", fd_cyc, 2051);
      full_rate = 1'b0;
   endtask

   initial begin
      int n;
      resetRd = 1'b1; imageProcessed = 1'b0; pixReady = 1'b0;
      tick(); tick();
      model_on = 1'b1;
      check_reset_outs("reset");
      tick();
      resetRd = 1'b0;
      tick();

      run_frame(0);
      chk("pin_pix255", pin255, 255);
      chk("pin_pix300", pin300, 45);
      chk("pin_pix1000", pin1000, 235);

      run_frame(1);
      run_frame(2);
      run_frame(3);

      imageProcessed = 1'b0; tick(); tick();
      imageProcessed = 1'b1; pixReady = 1'b1; tick();
      n = 0;
      while (acc_idx < 5 * SEG_LEN + 100 && n < 4 * N) begin
         pixReady = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      chk("reached_seg5", segSel, 5);
      resetRd = 1'b1; imageProcessed = 1'b0;
      tick();
      check_reset_outs("midreset");
      resetRd = 1'b0;
      tick();
      check_reset_outs("postreset");

      run_frame(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1);
   end

endmodule
